// File: rtl/pa_risc_trace_buffer.sv
// Instruction-trace circular buffer with per-class saturating counters and FWFT read port.
// Optional build macro TRACE_FILTER_NOP_EN: NOPs are counted but never stored.
module pa_risc_trace_buffer #(
   parameter int DEPTH  = 16,
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 16,
   parameter int MODE   = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     freeze,
   input  logic                     cap_valid,
   input  logic [PC_W-1:0]          cap_pc,
   input  logic [INST_W-1:0]        cap_inst,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [PC_W-1:0]          rd_pc,
   output logic [INST_W-1:0]        rd_inst,
   output logic [2:0]               rd_class,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_cnt,
   input  logic [2:0]               cnt_sel,
   output logic [CNT_W-1:0]         cnt_data
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   LVL_ONE = 1;
   localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
      logic [2:0]        cls;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [AW-1:0]     head, tail;
   logic [CNT_W-1:0]  cnt [8];
   logic [AW:0]       level_nxt;
   logic [2:0]        cap_cls;
   logic              capture, push, pop, drop, wr_en, head_adv;

   function automatic logic [2:0] classify(input logic [5:0] op);
      case (op)
         6'b000000:                                  return 3'd0;
         6'b000010:                                  return 3'd1;
         6'b010010, 6'b010001, 6'b010000:            return 3'd2;
         6'b011010, 6'b011001, 6'b011000:            return 3'd3;
         6'b001101, 6'b001000, 6'b101101, 6'b100101: return 3'd4;
         6'b111010, 6'b100000, 6'b100010:            return 3'd5;
         6'b110100, 6'b110101:                       return 3'd6;
         default:                                    return 3'd7;
      endcase
   endfunction

   assign cap_cls = classify(cap_inst[INST_W-1 -: 6]);
   assign capture = cap_valid && !freeze && !clear;
`ifdef TRACE_FILTER_NOP_EN
   assign push = capture && (cap_cls != 3'd0);
`else
   assign push = capture;
`endif
   assign rd_valid = !empty;
   assign pop      = rd_valid && rd_ready;
   // A concurrent pop frees a slot, so only a push into a full buffer without pop is lost.
   assign drop     = push && full && !pop;
   assign wr_en    = push && !(drop && MODE != 0);
   assign head_adv = pop || (drop && MODE == 0);

   always_comb begin
      level_nxt = level;
      if (wr_en && !head_adv)      level_nxt = level + LVL_ONE;
      else if (head_adv && !wr_en) level_nxt = level - LVL_ONE;
   end

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         head     <= '0;
         tail     <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
         drop_cnt <= '0;
         for (int i = 0; i < 8; i++) cnt[i] <= '0;
      end else begin
         if (wr_en)    tail <= tail + PTR_ONE;
         if (head_adv) head <= head + PTR_ONE;
         level <= level_nxt;
         full  <= (level_nxt == LVL_MAX);
         empty <= (level_nxt == '0);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
         end
         if (capture && cnt[cap_cls] != '1) cnt[cap_cls] <= cnt[cap_cls] + 1'b1;
      end
   end

   // Storage is not reset; rd_* are gated by rd_valid so stale contents never show.
   always_ff @(posedge clk) begin
      if (reset && wr_en) mem[tail] <= '{pc: cap_pc, inst: cap_inst, cls: cap_cls};
   end

   assign rd_pc    = rd_valid ? mem[head].pc   : '0;
   assign rd_inst  = rd_valid ? mem[head].inst : '0;
   assign rd_class = rd_valid ? mem[head].cls  : '0;
   assign cnt_data = cnt[cnt_sel];
endmodule

// File: tb/tb_pa_risc_trace_buffer.sv
// Scoreboard bench: two DEPTH=4 buffers (overwrite and stop mode) share one stimulus stream.
module tb_pa_risc_trace_buffer;
   logic        clk = 0, reset = 0, clear = 0, freeze = 0, cap_valid = 0, rd_ready = 0;
   logic [31:0] cap_pc = 0, cap_inst = 0;
   logic [2:0]  cnt_sel = 0;

   logic        rv [2], fl [2], em [2], ov [2];
   logic [31:0] rpc [2], rin [2];
   logic [2:0]  rcl [2], lvl [2];
   logic [15:0] drp [2], cd [2];

   typedef struct { logic [31:0] pc; logic [2:0] cls; } exp_t;
   exp_t q0[$], q1[$];
   exp_t e0, e1;
   int   errors = 0, checks = 0;

   pa_risc_trace_buffer #(.DEPTH(4), .MODE(0)) d0 (
      .clk(clk), .reset(reset), .clear(clear), .freeze(freeze), .cap_valid(cap_valid),
      .cap_pc(cap_pc), .cap_inst(cap_inst), .rd_valid(rv[0]), .rd_ready(rd_ready),
      .rd_pc(rpc[0]), .rd_inst(rin[0]), .rd_class(rcl[0]), .level(lvl[0]), .full(fl[0]),
      .empty(em[0]), .overflow(ov[0]), .drop_cnt(drp[0]), .cnt_sel(cnt_sel), .cnt_data(cd[0]));

   pa_risc_trace_buffer #(.DEPTH(4), .MODE(1)) d1 (
      .clk(clk), .reset(reset), .clear(clear), .freeze(freeze), .cap_valid(cap_valid),
      .cap_pc(cap_pc), .cap_inst(cap_inst), .rd_valid(rv[1]), .rd_ready(rd_ready),
      .rd_pc(rpc[1]), .rd_inst(rin[1]), .rd_class(rcl[1]), .level(lvl[1]), .full(fl[1]),
      .empty(em[1]), .overflow(ov[1]), .drop_cnt(drp[1]), .cnt_sel(cnt_sel), .cnt_data(cd[1]));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: each accepted head entry is compared with the oldest expected entry.
   always @(negedge clk) begin
      if (reset && rv[0] && rd_ready) begin
         if (q0.size() == 0) chk("m0_unexpected_pop", 1, 0);
         else begin
            e0 = q0.pop_front();
            chk("m0_pc", rpc[0], e0.pc);
            chk("m0_cls", rcl[0], e0.cls);
         end
      end
      if (reset && rv[1] && rd_ready) begin
         if (q1.size() == 0) chk("m1_unexpected_pop", 1, 0);
         else begin
            e1 = q1.pop_front();
            chk("m1_pc", rpc[1], e1.pc);
            chk("m1_cls", rcl[1], e1.cls);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic cap(input logic [31:0] pc, input logic [5:0] op);
      cap_valid = 1; cap_pc = pc; cap_inst = {op, 26'h0123456};
      tick();
      cap_valid = 0;
   endtask

   task automatic expq(input int i, input logic [31:0] pc, input logic [2:0] cls);
      exp_t e;
      e.pc = pc; e.cls = cls;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic drain(input int n);
      rd_ready = 1;
      repeat (n) tick();
      rd_ready = 0;
   endtask

   task automatic stat(input string t, input int i, input int l, input int f, input int em_e,
                       input int ov_e, input int dr);
      chk({t, "_level"}, lvl[i], l);
      chk({t, "_full"}, fl[i], f);
      chk({t, "_empty"}, em[i], em_e);
      chk({t, "_overflow"}, ov[i], ov_e);
      chk({t, "_drop"}, drp[i], dr);
   endtask

   task automatic ccnt(input string t, input int i, input int sel, input int exp);
      cnt_sel = 3'(sel); #1;
      chk($sformatf("%s_cnt%0d_dut%0d", t, sel, i), cd[i], exp);
   endtask

   task automatic idle_state(input string t);
      for (int i = 0; i < 2; i++) begin
         stat($sformatf("%s%0d", t, i), i, 0, 0, 1, 0, 0);
         chk($sformatf("%s%0d_rdvalid", t, i), rv[i], 0);
         chk($sformatf("%s%0d_rdpc", t, i), rpc[i], 0);
         chk($sformatf("%s%0d_rdinst", t, i), rin[i], 0);
         chk($sformatf("%s%0d_rdclass", t, i), rcl[i], 0);
         for (int s = 0; s < 8; s++) ccnt(t, i, s, 0);
      end
   endtask

   task automatic do_clear();
      clear = 1; tick(); clear = 0;
   endtask

   initial begin
      // Reset then idle
      repeat (2) tick();
      reset = 1; tick();
      idle_state("rst");

      // Fill and drain with ADD
      for (int k = 0; k < 4; k++) cap(32'(k*4), 6'b000010);
      for (int i = 0; i < 2; i++) stat($sformatf("fill%0d", i), i, 4, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin expq(0, 32'(k*4), 1); expq(1, 32'(k*4), 1); end
      drain(4);
      for (int i = 0; i < 2; i++) begin
         stat($sformatf("drain%0d", i), i, 0, 0, 1, 0, 0);
         ccnt("drain", i, 1, 4);
      end
      chk("drain_q0_left", q0.size(), 0);
      chk("drain_q1_left", q1.size(), 0);

      // Six LDW captures into a 4-deep buffer: overwrite vs stop
      for (int k = 0; k < 6; k++) cap(32'(k*4), 6'b010010);
      for (int i = 0; i < 2; i++) begin
         stat($sformatf("ovf%0d", i), i, 4, 1, 0, 1, 2);
         ccnt("ovf", i, 2, 6);
      end
      for (int pc = 8; pc <= 20; pc += 4) expq(0, 32'(pc), 2);
      for (int pc = 0; pc <= 12; pc += 4) expq(1, 32'(pc), 2);
      drain(4);
      chk("ovf_q0_left", q0.size(), 0);
      chk("ovf_q1_left", q1.size(), 0);
      for (int i = 0; i < 2; i++) stat($sformatf("ovfdrain%0d", i), i, 0, 0, 1, 1, 2);

      // Full with simultaneous push and pop
      do_clear();
      for (int k = 0; k < 4; k++) cap(32'(k*4), 6'b000010);
      for (int k = 0; k < 5; k++) begin expq(0, 32'(k*4), 1); expq(1, 32'(k*4), 1); end
      rd_ready = 1;
      cap(32'd16, 6'b000010);
      rd_ready = 0;
      for (int i = 0; i < 2; i++) stat($sformatf("pp%0d", i), i, 4, 1, 0, 0, 0);
      drain(4);
      chk("pp_q0_left", q0.size(), 0);
      chk("pp_q1_left", q1.size(), 0);
      for (int i = 0; i < 2; i++) stat($sformatf("ppdrain%0d", i), i, 0, 0, 1, 0, 0);

      // Freeze blocks captures
      do_clear();
      freeze = 1;
      for (int k = 0; k < 3; k++) cap(32'(k*4), 6'b000010);
      freeze = 0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("frz%0d_level", i), lvl[i], 0);
         ccnt("frz", i, 1, 0);
      end

      // NOP, NOP, BL
      cap(32'h100, 6'b000000);
      cap(32'h104, 6'b000000);
      cap(32'h108, 6'b111010);
      for (int i = 0; i < 2; i++) begin
         ccnt("nop", i, 0, 2);
         ccnt("nop", i, 5, 1);
`ifdef TRACE_FILTER_NOP_EN
         chk($sformatf("nop%0d_level", i), lvl[i], 1);
         chk($sformatf("nop%0d_headpc", i), rpc[i], 32'h108);
         chk($sformatf("nop%0d_headcls", i), rcl[i], 5);
`else
         chk($sformatf("nop%0d_level", i), lvl[i], 3);
         chk($sformatf("nop%0d_headpc", i), rpc[i], 32'h100);
         chk($sformatf("nop%0d_headcls", i), rcl[i], 0);
`endif
      end

      // Clear returns everything to reset values
      do_clear();
      idle_state("clr");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
